// File: rtl/montgomery_r2_precalc.sv
// Computes R2 = 2^(2*m_size) mod m by shift-and-conditional-subtract, one bit per clock,
// to feed the r_red input of montgomery_wrap.
module montgomery_r2_precalc #(
    parameter int unsigned NBITS = 4096,
    parameter int unsigned MSW   = $clog2(NBITS) + 3,
    parameter int unsigned CW    = $clog2(NBITS) + 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_p,
    input  logic [NBITS-1:0] m,
    input  logic [MSW-1:0]   m_size,
    output logic [NBITS-1:0] r_red,
    output logic             busy,
    output logic             err,
    output logic             done_irq_p
);

    typedef enum logic [1:0] {StIdle, StIter, StDone} state_e;

    state_e           state_q;
    logic [NBITS-1:0] m_q;
    logic [NBITS-1:0] acc_q;
    logic [CW-1:0]    cnt_q;
    logic [NBITS-1:0] r_red_q;
    logic             busy_q;
    logic             err_q;
    logic             done_q;

    logic [NBITS:0]   acc_dbl;
    logic [NBITS:0]   acc_sub;
    logic [NBITS-1:0] acc_d;
    logic             m_zero;

    // acc < m always holds, so the doubled value needs at most one subtraction of m.
    always_comb begin
        acc_dbl = {acc_q, 1'b0};
        acc_sub = acc_dbl - {1'b0, m_q};
        acc_d   = (acc_dbl >= {1'b0, m_q}) ? acc_sub[NBITS-1:0] : acc_dbl[NBITS-1:0];
        m_zero  = (m_q == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            m_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            r_red_q <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (enable_p) begin
                        m_q    <= m;
                        acc_q  <= (m == NBITS'(1)) ? '0 : NBITS'(1);
                        cnt_q  <= CW'({m_size, 1'b0});
                        busy_q <= 1'b1;
                        // A zero modulus has no valid residue; skip straight to reporting it.
                        state_q <= (m == '0) ? StDone : StIter;
                    end
                end
                StIter: begin
                    if (cnt_q == '0) begin
                        state_q <= StDone;
                    end else begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                StDone: begin
                    r_red_q <= m_zero ? '0 : acc_q;
                    err_q   <= m_zero;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign r_red      = r_red_q;
    assign busy       = busy_q;
    assign err        = err_q;
    assign done_irq_p = done_q;

endmodule

// File: tb/tb_montgomery_r2_precalc.sv
// Directed bench for montgomery_r2_precalc at NBITS=8 with hand-computed residues and latencies.
module tb_montgomery_r2_precalc;

    localparam int unsigned NBITS = 8;
    localparam int unsigned MSW   = $clog2(NBITS) + 3;
    localparam int unsigned CW    = $clog2(NBITS) + 5;

    logic             clk;
    logic             rst_n;
    logic             enable_p;
    logic [NBITS-1:0] m;
    logic [MSW-1:0]   m_size;
    logic [NBITS-1:0] r_red;
    logic             busy;
    logic             err;
    logic             done_irq_p;

    int n_cmp;
    int n_bad;

    montgomery_r2_precalc #(
        .NBITS(NBITS),
        .MSW  (MSW),
        .CW   (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable_p  (enable_p),
        .m         (m),
        .m_size    (m_size),
        .r_red     (r_red),
        .busy      (busy),
        .err       (err),
        .done_irq_p(done_irq_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Starts an operation at the next edge (E0) and follows it to done_irq_p.
    // With inject set, a second start request (m=7) is raised at E5 while busy.
    task automatic run_op(input string tag, input logic [NBITS-1:0] mv, input logic [MSW-1:0] ms,
                          input logic [NBITS-1:0] exp_r, input logic exp_err, input int exp_lat,
                          input bit inject);
        int n;
        int gaps;
        bit seen;
        n    = 0;
        gaps = 0;
        seen = 1'b0;
        enable_p = 1'b1;
        m        = mv;
        m_size   = ms;
        @(posedge clk);
        #1;
        enable_p = 1'b0;
        m        = 8'hA5;
        m_size   = 6'd3;
        if (!busy) gaps++;
        while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (done_irq_p) begin
                seen = 1'b1;
                break;
            end
            if (!busy) gaps++;
            if (inject && n == 4) begin
                enable_p = 1'b1;
                m        = 8'd7;
                m_size   = 6'd4;
            end else if (inject && n == 5) begin
                enable_p = 1'b0;
            end
        end
        check_eq({tag, "_seen"}, 32'(seen), 32'd1);
        check_eq({tag, "_lat"}, 32'(n), 32'(exp_lat));
        check_eq({tag, "_r_red"}, 32'(r_red), 32'(exp_r));
        check_eq({tag, "_err"}, 32'(err), 32'(exp_err));
        check_eq({tag, "_busy_gap"}, 32'(gaps), 32'd0);
        check_eq({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int dcount;
        n_cmp    = 0;
        n_bad    = 0;
        rst_n    = 1'b0;
        enable_p = 1'b0;
        m        = '0;
        m_size   = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_r_red", 32'(r_red), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_done", 32'(done_irq_p), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("m7_s4", 8'd7, 6'd4, 8'd4, 1'b0, 10, 1'b0);

        run_op("m255_s8", 8'd255, 6'd8, 8'd1, 1'b0, 18, 1'b0);
        // Back-to-back: start is raised during the done cycle.
        run_op("b2b_m13_s4", 8'd13, 6'd4, 8'd9, 1'b0, 10, 1'b0);
        @(posedge clk);
        #1;
        check_eq("done_pulse_width", 32'(done_irq_p), 32'd0);
        check_eq("r_red_hold", 32'(r_red), 32'd9);

        run_op("m1_s8", 8'd1, 6'd8, 8'd0, 1'b0, 18, 1'b0);
        run_op("m0", 8'd0, 6'd5, 8'd0, 1'b1, 1, 1'b0);
        m = 8'd99;
        repeat (3) @(posedge clk);
        #1;
        check_eq("err_hold", 32'(err), 32'd1);

        run_op("m7_s0", 8'd7, 6'd0, 8'd1, 1'b0, 2, 1'b0);
        run_op("ignore_busy_start", 8'd255, 6'd8, 8'd1, 1'b0, 18, 1'b1);
        @(posedge clk);
        #1;
        check_eq("ignored_start_no_op", 32'(busy), 32'd0);

        // Abort mid-run with reset, then restart.
        enable_p = 1'b1;
        m        = 8'd13;
        m_size   = 6'd4;
        @(posedge clk);
        #1;
        enable_p = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_eq("abort_r_red", 32'(r_red), 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_err", 32'(err), 32'd0);
        check_eq("abort_done", 32'(done_irq_p), 32'd0);
        rst_n  = 1'b1;
        dcount = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (done_irq_p) dcount++;
        end
        check_eq("abort_no_done", 32'(dcount), 32'd0);
        run_op("restart_m13_s4", 8'd13, 6'd4, 8'd9, 1'b0, 10, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
